// File: rtl/second_game_render_pkg.sv
// second_game_render_pkg
// Shared types and constants for the second game renderer:
//   rgb_t      - 12-bit 4:4:4 colour
//   state_t    - per-frame display state (play / pause dim / lose flash)
//   COL_*      - palette used by the colour mux
//   dim_rgb()  - halves every nibble of a colour (pause dimming)
package second_game_render_pkg;

    typedef logic [11:0] rgb_t;

    typedef enum logic [1:0] {
        ST_PLAY       = 2'd0,
        ST_PAUSE      = 2'd1,
        ST_LOSE_FLASH = 2'd2
    } state_t;

    localparam rgb_t COL_BG     = 12'h000;
    localparam rgb_t COL_BALL   = 12'hFF0;
    localparam rgb_t COL_OBST   = 12'h0F0;
    localparam rgb_t COL_LOSE   = 12'hF00;
    localparam rgb_t COL_BORDER = 12'hFFF;

    // Per-channel shift right by one; the top bit of each nibble becomes 0.
    function automatic rgb_t dim_rgb(input rgb_t c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction

endpackage

// File: rtl/second_game_frame_fsm.sv
// second_game_frame_fsm
// Per-frame display state. All state changes happen on i_frame_start only;
// a loss pulse seen at any time is latched in lose_pending and consumed at
// the next frame start (including a pulse in the frame-start cycle itself).
// Ports:
//   clk, arst_n    - clock, asynchronous active-low reset
//   i_frame_start  - one-cycle pulse, first cycle of a frame
//   i_is_lose      - one-cycle loss pulse
//   i_is_pause     - pause level
//   o_state        - current display state (registered)
//   o_flash        - background flash enable (registered)
module second_game_frame_fsm
    import second_game_render_pkg::*;
#(
    parameter int LOSE_FLASH_FRAMES = 60,
    parameter int FLASH_PERIOD_LOG2 = 3
) (
    input  logic   clk,
    input  logic   arst_n,
    input  logic   i_frame_start,
    input  logic   i_is_lose,
    input  logic   i_is_pause,
    output state_t o_state,
    output logic   o_flash
);

    localparam int CW = $clog2(LOSE_FLASH_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LOSE_FLASH_FRAMES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            lose_pending_q, lose_pending_d;
    logic            flash_q, flash_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        lose_pending_d = lose_pending_q | i_is_lose;
        if (i_frame_start) begin
            case (state_q)
                ST_PLAY, ST_PAUSE: begin
                    if (lose_pending_d) begin
                        state_d        = ST_LOSE_FLASH;
                        cnt_d          = CNT_LOAD;
                        lose_pending_d = 1'b0;
                    end else begin
                        state_d = i_is_pause ? ST_PAUSE : ST_PLAY;
                    end
                end
                ST_LOSE_FLASH: begin
                    // Leave when the counter reaches zero; <= 1 also guards
                    // against an underflow if the count is ever already 0.
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = i_is_pause ? ST_PAUSE : ST_PLAY;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: state_d = ST_PLAY;
            endcase
        end
        // Flash computed from next-state so the output stays registered.
        flash_d = (state_d == ST_LOSE_FLASH) && cnt_d[FLASH_PERIOD_LOG2];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q        <= ST_PLAY;
            cnt_q          <= '0;
            lose_pending_q <= 1'b0;
            flash_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lose_pending_q <= lose_pending_d;
            flash_q        <= flash_d;
        end
    end

    assign o_state = state_q;
    assign o_flash = flash_q;

endmodule

// File: rtl/second_game_renderer.sv
// second_game_renderer
// Turns the display scan into window-local query coordinates for the game
// engine and composes the engine's answers into a 12-bit colour stream.
// Pipeline: stage 0 (comb window test) -> stage 1 regs (o_screen_*) ->
// stage 1 comb (ball hit + colour mux) -> stage 2 regs (o_rgb*).
// Optional feature: define SECOND_GAME_RENDER_BORDER_EN to draw a 2-pixel
// white border inside the window, above the ball.
// Ports:
//   clk, arst_n                      - clock, asynchronous active-low reset
//   i_pixel_x/y, i_pixel_valid       - global scan position and qualifier
//   i_frame_start                    - first cycle of a frame
//   o_screen_x/y                     - window-local query to the engine
//   i_is_obstacle, i_ball_x/y        - engine answers for o_screen_*
//   i_is_lose, i_is_pause            - game status
//   o_in_window, o_rgb, o_rgb_valid  - colour output, two cycles after pixel
module second_game_renderer
    import second_game_render_pkg::*;
#(
    parameter int SECOND_GAME_START_X     = 400,
    parameter int SECOND_GAME_START_Y     = 0,
    parameter int SECOND_GAME_WIDTH       = 400,
    parameter int SECOND_GAME_HEIGHT      = 600,
    parameter int SECOND_GAME_SQUARE_SIZE = 20,
    parameter int LOSE_FLASH_FRAMES       = 60,
    parameter int FLASH_PERIOD_LOG2       = 3
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [9:0]  i_pixel_x,
    input  logic [9:0]  i_pixel_y,
    input  logic        i_pixel_valid,
    input  logic        i_frame_start,
    output logic [8:0]  o_screen_x,
    output logic [9:0]  o_screen_y,
    input  logic        i_is_obstacle,
    input  logic [8:0]  i_ball_x,
    input  logic [9:0]  i_ball_y,
    input  logic        i_is_lose,
    input  logic        i_is_pause,
    output logic        o_in_window,
    output logic [11:0] o_rgb,
    output logic        o_rgb_valid
);

    localparam logic [10:0]        X_LO  = 11'(SECOND_GAME_START_X);
    localparam logic [10:0]        Y_LO  = 11'(SECOND_GAME_START_Y);
    localparam logic [10:0]        W11   = 11'(SECOND_GAME_WIDTH);
    localparam logic [10:0]        H11   = 11'(SECOND_GAME_HEIGHT);
    localparam logic signed [10:0] RAD_S = 11'(SECOND_GAME_SQUARE_SIZE / 2);

    // ---------------- stage 0: window test ----------------
    // Offset from the window origin; a pixel left of / above the window
    // wraps to a large unsigned value, so one compare per axis covers both
    // the inclusive lower and exclusive upper edge.
    logic [10:0] dx, dy;
    logic        in_win0;

    assign dx      = {1'b0, i_pixel_x} - X_LO;
    assign dy      = {1'b0, i_pixel_y} - Y_LO;
    assign in_win0 = i_pixel_valid && (dx < W11) && (dy < H11);

    // ---------------- stage 1 registers ----------------
    logic [8:0] screen_x_q, screen_x_d;
    logic [9:0] screen_y_q, screen_y_d;
    logic       s1_valid_q, s1_valid_d;
    logic       s1_in_win_q, s1_in_win_d;

    always_comb begin
        screen_x_d  = in_win0 ? dx[8:0] : '0;
        screen_y_d  = in_win0 ? dy[9:0] : '0;
        s1_valid_d  = i_pixel_valid;
        s1_in_win_d = in_win0;
    end

    // ---------------- frame state ----------------
    state_t fsm_state;
    logic   fsm_flash;

    second_game_frame_fsm #(
        .LOSE_FLASH_FRAMES (LOSE_FLASH_FRAMES),
        .FLASH_PERIOD_LOG2 (FLASH_PERIOD_LOG2)
    ) u_frame_fsm (
        .clk           (clk),
        .arst_n        (arst_n),
        .i_frame_start (i_frame_start),
        .i_is_lose     (i_is_lose),
        .i_is_pause    (i_is_pause),
        .o_state       (fsm_state),
        .o_flash       (fsm_flash)
    );

    // ---------------- stage 1: ball hit ----------------
    // Signed 11-bit compare so ball_x - R near the left/top edge goes
    // negative instead of wrapping to a large local coordinate.
    logic signed [10:0] px_s, py_s, bx_s, by_s;
    logic               ball_hit;

    assign px_s     = signed'({2'b00, screen_x_q});
    assign py_s     = signed'({1'b0, screen_y_q});
    assign bx_s     = signed'({2'b00, i_ball_x});
    assign by_s     = signed'({1'b0, i_ball_y});
    assign ball_hit = (px_s >= bx_s - RAD_S) && (px_s <= bx_s + RAD_S) &&
                      (py_s >= by_s - RAD_S) && (py_s <= by_s + RAD_S);

`ifdef SECOND_GAME_RENDER_BORDER_EN
    localparam logic [8:0] BX_HI = 9'(SECOND_GAME_WIDTH - 2);
    localparam logic [9:0] BY_HI = 10'(SECOND_GAME_HEIGHT - 2);
    logic on_border;
    assign on_border = (screen_x_q < 9'd2) || (screen_x_q >= BX_HI) ||
                       (screen_y_q < 10'd2) || (screen_y_q >= BY_HI);
`endif

    // ---------------- stage 1: colour mux ----------------
    rgb_t rgb_q, rgb_d, colour;
    logic rgb_valid_q, rgb_valid_d;
    logic in_window_q, in_window_d;

    always_comb begin
        colour = fsm_flash ? COL_LOSE : COL_BG;
        if (i_is_obstacle) colour = COL_OBST;
        if (ball_hit)      colour = COL_BALL;
`ifdef SECOND_GAME_RENDER_BORDER_EN
        if (on_border)     colour = COL_BORDER;
`endif
        if (!s1_in_win_q)  colour = 12'h000;
        if (fsm_state == ST_PAUSE) colour = dim_rgb(colour);
        rgb_d       = colour;
        rgb_valid_d = s1_valid_q;
        in_window_d = s1_in_win_q;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            screen_x_q  <= '0;
            screen_y_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_in_win_q <= 1'b0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
            in_window_q <= 1'b0;
        end else begin
            screen_x_q  <= screen_x_d;
            screen_y_q  <= screen_y_d;
            s1_valid_q  <= s1_valid_d;
            s1_in_win_q <= s1_in_win_d;
            rgb_q       <= rgb_d;
            rgb_valid_q <= rgb_valid_d;
            in_window_q <= in_window_d;
        end
    end

    assign o_screen_x  = screen_x_q;
    assign o_screen_y  = screen_y_q;
    assign o_rgb       = rgb_q;
    assign o_rgb_valid = rgb_valid_q;
    assign o_in_window = in_window_q;

endmodule

// File: tb/tb_second_game_renderer.sv
// Bench for second_game_renderer: directed vector table, frame-state
// sequences (lose flash, pause, mid-frame reset) and random pixels checked
// against an integer reference model of the colour rules.
module tb_second_game_renderer;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [9:0]  i_pixel_x = '0, i_pixel_y = '0;
    logic        i_pixel_valid = 1'b0, i_frame_start = 1'b0;
    logic [8:0]  o_screen_x;
    logic [9:0]  o_screen_y;
    logic        i_is_obstacle = 1'b0;
    logic [8:0]  i_ball_x = '0;
    logic [9:0]  i_ball_y = '0;
    logic        i_is_lose = 1'b0, i_is_pause = 1'b0;
    logic        o_in_window;
    logic [11:0] o_rgb;
    logic        o_rgb_valid;

    int checks = 0;
    int failures = 0;

    second_game_renderer dut (
        .clk (clk), .arst_n (arst_n),
        .i_pixel_x (i_pixel_x), .i_pixel_y (i_pixel_y),
        .i_pixel_valid (i_pixel_valid), .i_frame_start (i_frame_start),
        .o_screen_x (o_screen_x), .o_screen_y (o_screen_y),
        .i_is_obstacle (i_is_obstacle), .i_ball_x (i_ball_x), .i_ball_y (i_ball_y),
        .i_is_lose (i_is_lose), .i_is_pause (i_is_pause),
        .o_in_window (o_in_window), .o_rgb (o_rgb), .o_rgb_valid (o_rgb_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference model straight from the colour rules, in plain integers.
    function automatic logic [11:0] ref_rgb(input int x, input int y, input bit v,
                                            input bit ob, input int bx, input int by,
                                            input bit pause, input bit flash);
        int lx, ly;
        logic [11:0] c;
        if (!(v && x >= 400 && x < 800 && y >= 0 && y < 600)) return 12'h000;
        lx = x - 400;
        ly = y;
        c = flash ? 12'hF00 : 12'h000;
        if (ob) c = 12'h0F0;
        if (lx >= bx - 10 && lx <= bx + 10 && ly >= by - 10 && ly <= by + 10) c = 12'hFF0;
        if (pause) c = (c >> 1) & 12'h777;
        return c;
    endfunction

    function automatic bit ref_win(input int x, input int y, input bit v);
        return v && x >= 400 && x < 800 && y < 600;
    endfunction

    // Present one pixel, check o_screen_* one cycle later and the colour
    // outputs two cycles later; engine inputs held throughout.
    task automatic run_px(input string nm, input int x, input int y, input bit v,
                          input bit ob, input int bx, input int by,
                          input bit ewin, input logic [11:0] ergb,
                          input int esx, input int esy);
        @(negedge clk);
        i_pixel_x = 10'(x); i_pixel_y = 10'(y); i_pixel_valid = v;
        i_is_obstacle = ob; i_ball_x = 9'(bx); i_ball_y = 10'(by);
        @(posedge clk); #1;
        check({nm, ".sx"}, 32'(o_screen_x), 32'(esx));
        check({nm, ".sy"}, 32'(o_screen_y), 32'(esy));
        @(posedge clk); #1;
        check({nm, ".rgb"}, 32'(o_rgb), 32'(ergb));
        check({nm, ".win"}, 32'(o_in_window), 32'(ewin));
        check({nm, ".vld"}, 32'(o_rgb_valid), 32'(v));
    endtask

    task automatic frame_pulse(input bit lose);
        @(negedge clk);
        i_pixel_valid = 1'b0; i_frame_start = 1'b1; i_is_lose = lose;
        @(negedge clk);
        i_frame_start = 1'b0; i_is_lose = 1'b0;
    endtask

    task automatic lose_pulse();
        @(negedge clk);
        i_is_lose = 1'b1;
        @(negedge clk);
        i_is_lose = 1'b0;
    endtask

    typedef struct {
        int x, y; bit v, ob; int bx, by;
        bit win; logic [11:0] rgb; int sx, sy;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{400, 0,   1, 0, 100, 300, 1, 12'h000, 0,   0};
        tbl[1]  = '{399, 10,  1, 0, 100, 300, 0, 12'h000, 0,   0};
        tbl[2]  = '{800, 10,  1, 0, 100, 300, 0, 12'h000, 0,   0};
        tbl[3]  = '{610, 510, 1, 0, 200, 500, 1, 12'hFF0, 210, 510};
        tbl[4]  = '{611, 510, 1, 1, 200, 500, 1, 12'h0F0, 211, 510};
        tbl[5]  = '{400, 0,   1, 0, 5,   5,   1, 12'hFF0, 0,   0};
        tbl[6]  = '{415, 15,  1, 0, 5,   5,   1, 12'hFF0, 15,  15};
        tbl[7]  = '{416, 15,  1, 1, 5,   5,   1, 12'h0F0, 16,  15};
        tbl[8]  = '{799, 0,   1, 0, 5,   5,   1, 12'h000, 399, 0};
        tbl[9]  = '{799, 599, 1, 1, 100, 300, 1, 12'h0F0, 399, 599};
        tbl[10] = '{500, 600, 1, 1, 100, 300, 0, 12'h000, 0,   0};
        tbl[11] = '{500, 300, 0, 1, 100, 300, 0, 12'h000, 0,   0};
        tbl[12] = '{590, 10,  1, 0, 200, 0,   1, 12'hFF0, 190, 10};
        tbl[13] = '{799, 5,   1, 0, 0,   0,   1, 12'h000, 399, 5};
        tbl[14] = '{411, 0,   1, 0, 0,   0,   1, 12'h000, 11,  0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.rgb", 32'(o_rgb), 0);
        check("rst.vld", 32'(o_rgb_valid), 0);
        check("rst.win", 32'(o_in_window), 0);
        check("rst.sx", 32'(o_screen_x), 0);
        check("rst.sy", 32'(o_screen_y), 0);
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 15; i++)
            run_px($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].ob,
                   tbl[i].bx, tbl[i].by, tbl[i].win, tbl[i].rgb, tbl[i].sx, tbl[i].sy);

        // lose mid-frame: no effect until the next frame start
        lose_pulse();
        run_px("lose_pre", 500, 300, 1, 0, 300, 100, 1, 12'h000, 100, 300);
        frame_pulse(1'b0);
        for (int k = 0; k < 60; k++) begin
            logic [11:0] e;
            e = (((60 - k) >> 3) & 1) != 0 ? 12'hF00 : 12'h000;
            run_px($sformatf("flash%0d", k), 500, 300, 1, 0, 300, 100, 1, e, 100, 300);
            if (k == 0)
                run_px("flash_obst", 500, 300, 1, 1, 300, 100, 1, 12'h0F0, 100, 300);
            frame_pulse(1'b0);
        end
        run_px("flash_end", 500, 300, 1, 0, 300, 100, 1, 12'h000, 100, 300);

        // pause: dimmed colours
        i_is_pause = 1'b1;
        frame_pulse(1'b0);
        run_px("pause_ball", 610, 510, 1, 0, 200, 500, 1, 12'h770, 210, 510);
        run_px("pause_obst", 611, 520, 1, 1, 0, 0, 1, 12'h070, 211, 520);
        for (int i = 0; i < 120; i++) begin
            int x, y, bx, by; bit v, ob;
            bx = $urandom_range(0, 511); by = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1) begin
                x = 400 + bx + $urandom_range(0, 24) - 12; y = by + $urandom_range(0, 24) - 12;
                if (x < 0) x = 0; if (x > 1023) x = 1023;
                if (y < 0) y = 0; if (y > 1023) y = 1023;
            end else begin
                x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
            end
            v = ($urandom_range(0, 7) != 0); ob = $urandom_range(0, 1);
            run_px($sformatf("rndp%0d", i), x, y, v, ob, bx, by, ref_win(x, y, v),
                   ref_rgb(x, y, v, ob, bx, by, 1'b1, 1'b0),
                   ref_win(x, y, v) ? x - 400 : 0, ref_win(x, y, v) ? y : 0);
        end
        i_is_pause = 1'b0;
        frame_pulse(1'b0);
        for (int i = 0; i < 150; i++) begin
            int x, y, bx, by; bit v, ob;
            bx = $urandom_range(0, 511); by = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1) begin
                x = 400 + bx + $urandom_range(0, 24) - 12; y = by + $urandom_range(0, 24) - 12;
                if (x < 0) x = 0; if (x > 1023) x = 1023;
                if (y < 0) y = 0; if (y > 1023) y = 1023;
            end else begin
                x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
            end
            v = ($urandom_range(0, 7) != 0); ob = $urandom_range(0, 1);
            run_px($sformatf("rnd%0d", i), x, y, v, ob, bx, by, ref_win(x, y, v),
                   ref_rgb(x, y, v, ob, bx, by, 1'b0, 1'b0),
                   ref_win(x, y, v) ? x - 400 : 0, ref_win(x, y, v) ? y : 0);
        end

        // lose in the frame-start cycle itself enters flash at that start
        frame_pulse(1'b1);
        run_px("lose_same", 500, 300, 1, 0, 300, 100, 1, 12'hF00, 100, 300);

        // reset mid-frame while flashing and streaming pixels
        @(negedge clk);
        i_pixel_valid = 1'b1;
        @(posedge clk); #2;
        arst_n = 1'b0;
        #1;
        check("mrst.vld", 32'(o_rgb_valid), 0);
        check("mrst.rgb", 32'(o_rgb), 0);
        check("mrst.win", 32'(o_in_window), 0);
        check("mrst.sx", 32'(o_screen_x), 0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;
        check("mrst.lat1", 32'(o_rgb_valid), 0);
        @(posedge clk); #1;
        check("mrst.lat2", 32'(o_rgb_valid), 1);
        check("mrst.play", 32'(o_rgb), 32'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/second_game_renderer.md
# second_game_renderer

Pixel-side partner of the second game engine: walks the display scan, turns global pixel coordinates into window-local query coordinates for the engine, and composes the returned obstacle flag, ball position and game status into a 12-bit colour stream. Sits between the display timing generator and the top-level colour mux. It also owns the per-frame display state (play / pause dim / lose flash).

## Interface
- SECOND_GAME_START_X, 400, window left edge in global pixels
- SECOND_GAME_START_Y, 0, window top edge in global pixels
- SECOND_GAME_WIDTH, 400, window width
- SECOND_GAME_HEIGHT, 600, window height
- SECOND_GAME_SQUARE_SIZE, 20, ball square side; radius R = SIZE/2
- LOSE_FLASH_FRAMES, 60, frames spent in lose flash
- FLASH_PERIOD_LOG2, 3, flash toggles every 2^N frames
---
- clk  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- i_pixel_x  in  10  global scan column
- i_pixel_y  in  10  global scan row
- i_pixel_valid  in  1  active-video qualifier
- i_frame_start  in  1  one-cycle pulse, first cycle of a frame
- o_screen_x  out  9  window-local x query to engine
- o_screen_y  out  10  window-local y query to engine
- i_is_obstacle  in  1  engine's combinational answer for o_screen_x/y
- i_ball_x  in  9, i_ball_y  in  10  ball centre, window-local
- i_is_lose  in  1  one-cycle loss pulse from engine
- i_is_pause  in  1  pause level
- o_in_window  out  1  o_rgb belongs to the game window
- o_rgb  out  12  colour, 4:4:4 R:G:B
- o_rgb_valid  out  1  o_rgb qualifier

## Operation
- Stage 0 (comb): in_win = valid && START_X <= x < START_X+WIDTH && START_Y <= y < START_Y+HEIGHT. Local x = (x-START_X) truncated to 9 bits, local y = (y-START_Y) to 10 bits.
- Stage 1 (reg): o_screen_x/y <= local coords when in_win, else 0; valid/in_win delayed alongside.
- Ball hit (stage 1, 11-bit signed): ball_x-R <= sx <= ball_x+R and ball_y-R <= sy <= ball_y+R; negative bounds must not wrap.
- Colour priority: outside window 0x000; ball 0xFF0; obstacle 0x0F0; background 0x000 (0xF00 when flashing).
- FSM, updates only on i_frame_start:
  - PLAY: lose_pending -> LOSE_FLASH (counter = LOSE_FLASH_FRAMES, clear pending); else i_is_pause -> PAUSE.
  - PAUSE: lose_pending -> LOSE_FLASH; !i_is_pause -> PLAY.
  - LOSE_FLASH: decrement counter; at 0 -> PLAY (PAUSE if i_is_pause).
- lose_pending: set on any i_is_lose pulse, including the same cycle as i_frame_start (that frame start then enters LOSE_FLASH).
- Flashing: in LOSE_FLASH when counter bit FLASH_PERIOD_LOG2 is 1.
- PAUSE: each nibble of the final colour shifted right by 1.
- Counter width: $clog2(LOSE_FLASH_FRAMES+1).

## Timing
- Latency two cycles from i_pixel_* to o_rgb/o_rgb_valid/o_in_window; one cycle to o_screen_*.
- i_is_obstacle and i_ball_* sampled in the cycle o_screen_* is presented.
- Reset values: all outputs 0, FSM PLAY, counter 0, lose_pending 0.
- Reset mid-frame: outputs clear immediately. First valid colour two cycles after first valid pixel post-release. FSM waits for next i_frame_start.
- Window edges inclusive on left/top, exclusive on right/bottom.

## Configuration
- SECOND_GAME_RENDER_BORDER_EN defined: in-window pixels with local x or y < 2, x >= WIDTH-2 or y >= HEIGHT-2 forced to 0xFFF, above ball. Pause dimming still applies.
- Undefined: no border logic; colour priority as above.

## Structure
- Package second_game_render_pkg holds:
  - rgb_t (12-bit)
  - state enum (ST_PLAY, ST_PAUSE, ST_LOSE_FLASH)
  - colour constants (COL_BG, COL_BALL, COL_OBST, COL_LOSE, COL_BORDER)
- Sub-module second_game_frame_fsm holds the state, lose_pending, frame counter; outputs state and flash flag.
- Pixel pipeline and colour mux stay in the top.

## Test plan
- Pixel (400,0) valid, obstacle=0, ball far -> o_screen=(0,0) next cycle, o_rgb=0x000, in_window=1 two cycles later.
- Pixel (399,10) -> o_in_window=0, o_rgb=0x000. Pixel (800,10) -> o_in_window=0.
- Ball (200,500), pixel (610,510) -> 0xFF0; pixel (611,510) with obstacle=1 -> 0x0F0.
- Ball (5,5), pixel (400,0) -> 0xFF0, no wrap false hits at local x 500.
- i_is_lose pulse mid-frame -> LOSE_FLASH at next frame start. Background 0xF00 in frames where counter bit 3 set. PLAY after 60 frames.
- i_is_pause high at frame start -> ball renders 0x770. Reset mid-frame -> o_rgb_valid=0 immediately.
